// File: rtl/lvds_pkg.sv
// Shared LVDS panel-link definitions: clock-lane pattern, data-lane bit map,
// lock FSM states and small helpers used by the receive decoder.
package lvds_pkg;

   localparam logic [6:0] CLK_PATTERN_DEF = 7'b1100011;
   localparam int         WORD_W          = 7;
   localparam int         NUM_LANES       = 4;
   localparam int         COORD_W         = 12;
   localparam logic [COORD_W-1:0] COORD_MAX = '1;

   // Bit positions inside aligned data-lane words; bit 6 is first on the wire.
   localparam int L0_G0   = 6;
   localparam int L1_B0   = 5;
   localparam int L1_B1   = 6;
   localparam int L2_HS   = 4;
   localparam int L2_VS   = 5;
   localparam int L2_DE   = 6;
   localparam int L3_R6   = 0;
   localparam int L3_R7   = 1;
   localparam int L3_G6   = 2;
   localparam int L3_G7   = 3;
   localparam int L3_B6   = 4;
   localparam int L3_B7   = 5;
   localparam int L3_RSVD = 6;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } lvds_state_e;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
      logic       hs;
      logic       vs;
      logic       de;
   } lvds_pixel_t;

   function automatic lvds_pixel_t decode_pixel(
      input logic [WORD_W-1:0] w0,
      input logic [WORD_W-1:0] w1,
      input logic [WORD_W-1:0] w2,
      input logic [WORD_W-1:0] w3
   );
      lvds_pixel_t p;
      p.r  = {w3[L3_R7], w3[L3_R6], w0[5:0]};
      p.g  = {w3[L3_G7], w3[L3_G6], w1[4:0], w0[L0_G0]};
      p.b  = {w3[L3_B7], w3[L3_B6], w2[3:0], w1[L1_B1], w1[L1_B0]};
      p.hs = w2[L2_HS];
      p.vs = w2[L2_VS];
      p.de = w2[L2_DE];
      return p;
   endfunction

   function automatic logic [COORD_W-1:0] sat_inc(input logic [COORD_W-1:0] v);
      return (v == COORD_MAX) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/lvds_word_align.sv
// One lane of word alignment: remembers the previous accepted word and picks a
// 7-bit window out of {prev, cur} selected by the shared bit-slip offset.
module lvds_word_align
   import lvds_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_resetn,
   input  logic              i_en,
   input  logic [WORD_W-1:0] i_word,
   input  logic [2:0]        i_offset,
   output logic [WORD_W-1:0] o_window
);

   logic [WORD_W-1:0] prev_q, prev_d;
   logic [12:0]       cat;

   // The LSB of the current word never reaches any window, so it is left out.
   always_comb begin
      prev_d = i_en ? i_word : prev_q;
      cat    = {prev_q, i_word[6:1]};
      case (i_offset)
         3'd0:    o_window = cat[12:6];
         3'd1:    o_window = cat[11:5];
         3'd2:    o_window = cat[10:4];
         3'd3:    o_window = cat[9:3];
         3'd4:    o_window = cat[8:2];
         3'd5:    o_window = cat[7:1];
         3'd6:    o_window = cat[6:0];
         default: o_window = cat[12:6];
      endcase
   end

   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         prev_q <= '0;
      end else begin
         prev_q <= prev_d;
      end
   end

endmodule

// File: rtl/lvds_rx_decoder.sv
// LVDS panel receiver: clock-lane word alignment with a lock FSM, VESA 24-bit
// pixel decode with HS/VS/DE, and regenerated x/y coordinates.
//
// state  | meaning
// SEARCH | slipping the shared bit offset until the clock-lane window matches
// VERIFY | pattern seen; counting consecutive matches before trusting it
// LOCKED | aligned; pixels decoded, up to UNLOCK_ERRS-1 bad clock words tolerated
module lvds_rx_decoder
   import lvds_pkg::*;
#(
   parameter int         LOCK_COUNT  = 16,
   parameter int         UNLOCK_ERRS = 4,
   parameter logic [6:0] CLK_PATTERN = CLK_PATTERN_DEF
) (
   input  logic        i_clk,
   input  logic        i_resetn,
   input  logic        i_word_valid,
   input  logic [6:0]  i_clk_lane,
   input  logic [27:0] i_lanes,
   output logic        o_valid,
   output logic [23:0] o_color,
   output logic        o_hs,
   output logic        o_vs,
   output logic        o_de,
   output logic [11:0] o_x,
   output logic [11:0] o_y,
   output logic        o_locked,
   output logic [2:0]  o_offset
);

   localparam int LCNT_W = (LOCK_COUNT > 2) ? $clog2(LOCK_COUNT) : 1;
   localparam int ERR_W  = (UNLOCK_ERRS > 2) ? $clog2(UNLOCK_ERRS) : 1;
   localparam logic [LCNT_W-1:0] LCNT_LOAD = LCNT_W'(LOCK_COUNT - 2);
   localparam logic [ERR_W-1:0]  ERR_LOAD  = ERR_W'(UNLOCK_ERRS - 1);

   lvds_state_e                      state_q, state_d;
   logic [2:0]                       off_q, off_d, off_next;
   logic [LCNT_W-1:0]                lcnt_q, lcnt_d;
   logic [ERR_W-1:0]                 err_q, err_d;
   logic                             locked_q, locked_d;
   logic                             s1_valid_q, s1_valid_d;
   logic                             s1_clear_q, s1_clear_d;
   logic [NUM_LANES-1:0][WORD_W-1:0] s1_word_q, s1_word_d;

   logic [WORD_W-1:0]                w_clk;
   logic [NUM_LANES-1:0][WORD_W-1:0] w_data;
   logic                             match;

   logic                             valid_q, valid_d;
   logic [23:0]                      color_q, color_d;
   logic                             hs_q, hs_d, vs_q, vs_d, de_q, de_d;
   logic [COORD_W-1:0]               ox_q, ox_d, oy_q, oy_d;
   logic [COORD_W-1:0]               x_q, x_d, y_q, y_d;
   logic                             de_prev_q, de_prev_d, vs_prev_q, vs_prev_d;
   logic                             hist_q, hist_d;

   lvds_pixel_t                      pix;
   logic                             de_fall, vs_rise;
   logic [COORD_W-1:0]               x_base, y_base;
   logic                             unused_rsvd;

   lvds_word_align u_align_clk (
      .i_clk    (i_clk),
      .i_resetn (i_resetn),
      .i_en     (i_word_valid),
      .i_word   (i_clk_lane),
      .i_offset (off_q),
      .o_window (w_clk)
   );

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      lvds_word_align u_align (
         .i_clk    (i_clk),
         .i_resetn (i_resetn),
         .i_en     (i_word_valid),
         .i_word   (i_lanes[WORD_W*g +: WORD_W]),
         .i_offset (off_q),
         .o_window (w_data[g])
      );
   end

   assign match       = (w_clk == CLK_PATTERN);
   assign off_next    = (off_q == 3'd6) ? 3'd0 : off_q + 3'd1;
   assign unused_rsvd = s1_word_q[3][L3_RSVD];

   // Stage 1: lock FSM and aligned-word capture; only accepted words move it.
   always_comb begin
      state_d    = state_q;
      off_d      = off_q;
      lcnt_d     = lcnt_q;
      err_d      = err_q;
      locked_d   = locked_q;
      s1_valid_d = 1'b0;
      s1_clear_d = 1'b0;
      s1_word_d  = s1_word_q;
      if (i_word_valid) begin
         case (state_q)
            SEARCH: begin
               if (match) begin
                  state_d = VERIFY;
                  lcnt_d  = LCNT_LOAD;
               end else begin
                  off_d = off_next;
               end
            end
            VERIFY: begin
               if (!match) begin
                  state_d = SEARCH;
                  off_d   = off_next;
               end else if (lcnt_q == '0) begin
                  state_d  = LOCKED;
                  locked_d = 1'b1;
                  err_d    = ERR_LOAD;
               end else begin
                  lcnt_d = lcnt_q - 1'b1;
               end
            end
            LOCKED: begin
               if (match) begin
                  err_d      = ERR_LOAD;
                  s1_valid_d = 1'b1;
               end else if (err_q == '0) begin
                  state_d    = SEARCH;
                  locked_d   = 1'b0;
                  s1_clear_d = 1'b1;
               end else begin
                  err_d      = err_q - 1'b1;
                  s1_valid_d = 1'b1;
               end
            end
            default: begin
               state_d  = SEARCH;
               locked_d = 1'b0;
            end
         endcase
         if (s1_valid_d) begin
            s1_word_d = w_data;
         end
      end
   end

   // Stage 2: decode and coordinates; edges only count once history is valid.
   always_comb begin
      pix     = decode_pixel(s1_word_q[0], s1_word_q[1], s1_word_q[2], s1_word_q[3]);
      de_fall = hist_q & de_prev_q & ~pix.de;
      vs_rise = hist_q & ~vs_prev_q & pix.vs;
      x_base  = de_fall ? '0 : x_q;
      if (vs_rise) begin
         y_base = '0;
      end else if (de_fall) begin
         y_base = sat_inc(y_q);
      end else begin
         y_base = y_q;
      end

      valid_d   = 1'b0;
      color_d   = color_q;
      hs_d      = hs_q;
      vs_d      = vs_q;
      de_d      = de_q;
      ox_d      = ox_q;
      oy_d      = oy_q;
      x_d       = x_q;
      y_d       = y_q;
      de_prev_d = de_prev_q;
      vs_prev_d = vs_prev_q;
      hist_d    = hist_q;

      if (s1_clear_q) begin
         x_d       = '0;
         y_d       = '0;
         de_prev_d = 1'b0;
         vs_prev_d = 1'b0;
         hist_d    = 1'b0;
      end else if (s1_valid_q) begin
         valid_d   = 1'b1;
         color_d   = {pix.r, pix.g, pix.b};
         hs_d      = pix.hs;
         vs_d      = pix.vs;
         de_d      = pix.de;
         ox_d      = x_base;
         oy_d      = y_base;
         x_d       = pix.de ? sat_inc(x_base) : x_base;
         y_d       = y_base;
         de_prev_d = pix.de;
         vs_prev_d = pix.vs;
         hist_d    = 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         state_q    <= SEARCH;
         off_q      <= '0;
         lcnt_q     <= '0;
         err_q      <= '0;
         locked_q   <= 1'b0;
         s1_valid_q <= 1'b0;
         s1_clear_q <= 1'b0;
         s1_word_q  <= '0;
         valid_q    <= 1'b0;
         color_q    <= '0;
         hs_q       <= 1'b0;
         vs_q       <= 1'b0;
         de_q       <= 1'b0;
         ox_q       <= '0;
         oy_q       <= '0;
         x_q        <= '0;
         y_q        <= '0;
         de_prev_q  <= 1'b0;
         vs_prev_q  <= 1'b0;
         hist_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         off_q      <= off_d;
         lcnt_q     <= lcnt_d;
         err_q      <= err_d;
         locked_q   <= locked_d;
         s1_valid_q <= s1_valid_d;
         s1_clear_q <= s1_clear_d;
         s1_word_q  <= s1_word_d;
         valid_q    <= valid_d;
         color_q    <= color_d;
         hs_q       <= hs_d;
         vs_q       <= vs_d;
         de_q       <= de_d;
         ox_q       <= ox_d;
         oy_q       <= oy_d;
         x_q        <= x_d;
         y_q        <= y_d;
         de_prev_q  <= de_prev_d;
         vs_prev_q  <= vs_prev_d;
         hist_q     <= hist_d;
      end
   end

   assign o_valid  = valid_q;
   assign o_color  = color_q;
   assign o_hs     = hs_q;
   assign o_vs     = vs_q;
   assign o_de     = de_q;
   assign o_x      = ox_q;
   assign o_y      = oy_q;
   assign o_locked = locked_q;
   assign o_offset = off_q;

endmodule

// File: tb/tb_lvds_rx_decoder.sv
// Scoreboard bench for lvds_rx_decoder: a transmitter-side generator feeds
// bit-slipped raw words, a word-level reference model predicts pixels.
module tb_lvds_rx_decoder;

   localparam logic [6:0] PAT         = 7'b1100011;
   localparam logic [6:0] BAD         = 7'b1100111;
   localparam int         LOCK_COUNT  = 16;
   localparam int         UNLOCK_ERRS = 4;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        wv = 1'b0;
   logic [6:0]  clk_lane = '0;
   logic [27:0] lanes = '0;
   logic        o_valid, o_hs, o_vs, o_de, o_locked;
   logic [23:0] o_color;
   logic [11:0] o_x, o_y;
   logic [2:0]  o_offset;

   always #5 clk = ~clk;

   lvds_rx_decoder #(
      .LOCK_COUNT  (LOCK_COUNT),
      .UNLOCK_ERRS (UNLOCK_ERRS),
      .CLK_PATTERN (PAT)
   ) dut (
      .i_clk        (clk),
      .i_resetn     (rstn),
      .i_word_valid (wv),
      .i_clk_lane   (clk_lane),
      .i_lanes      (lanes),
      .o_valid      (o_valid),
      .o_color      (o_color),
      .o_hs         (o_hs),
      .o_vs         (o_vs),
      .o_de         (o_de),
      .o_x          (o_x),
      .o_y          (o_y),
      .o_locked     (o_locked),
      .o_offset     (o_offset)
   );

   typedef struct {
      logic [23:0] color;
      logic        hs, vs, de;
      int          x, y;
      longint      cyc;
   } exp_t;

   int     vectors = 0;
   int     errors  = 0;
   longint cyc     = 0;
   exp_t   sb[$];
   exp_t   e;

   // transmitter side: previous aligned word per lane (0 = clock lane)
   logic [6:0] a_prev[5];

   // reference model state, in the terms of the lock/decode rules
   logic [6:0] m_prev[5];
   int         m_off, m_state, m_matches, m_errs;
   int         m_x, m_y;
   bit         m_hist, m_de_prev, m_vs_prev;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic model_reset();
      for (int l = 0; l < 5; l++) m_prev[l] = '0;
      m_off = 0; m_state = 0; m_matches = 0; m_errs = 0;
      m_x = 0; m_y = 0; m_hist = 0; m_de_prev = 0; m_vs_prev = 0;
      sb.delete();
   endtask

   task automatic model_word(input logic [6:0] raw[5]);
      logic [6:0]  w[5];
      logic [13:0] cat;
      bit          match, emit, lost, de_fall, vs_rise;
      exp_t        x;
      for (int l = 0; l < 5; l++) begin
         cat      = {m_prev[l], raw[l]};
         w[l]     = 7'(cat >> (7 - m_off));
         m_prev[l] = raw[l];
      end
      match = (w[0] == PAT);
      emit  = 0;
      lost  = 0;
      if (m_state == 0) begin
         if (match) begin m_state = 1; m_matches = 1; end
         else m_off = (m_off + 1) % 7;
      end else if (m_state == 1) begin
         if (match) begin
            m_matches++;
            if (m_matches == LOCK_COUNT) begin m_state = 2; m_errs = 0; end
         end else begin
            m_state = 0;
            m_off   = (m_off + 1) % 7;
         end
      end else begin
         if (match) begin m_errs = 0; emit = 1; end
         else begin
            m_errs++;
            if (m_errs == UNLOCK_ERRS) begin m_state = 0; lost = 1; end
            else emit = 1;
         end
      end
      if (lost) begin
         m_x = 0; m_y = 0; m_hist = 0; m_de_prev = 0; m_vs_prev = 0;
      end
      if (emit) begin
         x.color = {w[4][1:0], w[1][5:0], w[4][3:2], w[2][4:0], w[1][6],
                    w[4][5:4], w[3][3:0], w[2][6:5]};
         x.hs = w[3][4];
         x.vs = w[3][5];
         x.de = w[3][6];
         de_fall = m_hist && m_de_prev && !x.de;
         vs_rise = m_hist && !m_vs_prev && x.vs;
         if (vs_rise) m_y = 0;
         else if (de_fall && m_y < 4095) m_y = m_y + 1;
         if (de_fall) m_x = 0;
         x.x   = m_x;
         x.y   = m_y;
         x.cyc = cyc + 2;
         sb.push_back(x);
         if (x.de && m_x < 4095) m_x = m_x + 1;
         m_de_prev = x.de;
         m_vs_prev = x.vs;
         m_hist    = 1;
      end
   endtask

   task automatic check_status();
      vectors++;
      if (o_locked !== (m_state == 2) || o_offset !== 3'(m_off)) begin
         errors++;
         $display("FAIL status @%0d: locked=%b offset=%0d, want locked=%0d offset=%0d",
                  cyc, o_locked, o_offset, (m_state == 2), m_off);
      end
   endtask

   task automatic check_reset_outputs(input string name);
      vectors++;
      if ({o_valid, o_color, o_hs, o_vs, o_de, o_x, o_y, o_locked, o_offset} !== '0) begin
         errors++;
         $display("FAIL %s: valid=%b color=%h hs/vs/de=%b%b%b x=%0d y=%0d locked=%b off=%0d, want all 0",
                  name, o_valid, o_color, o_hs, o_vs, o_de, o_x, o_y, o_locked, o_offset);
      end
   endtask

   task automatic expect_bit(input string name, input logic got, input logic want);
      vectors++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %b, want %b", name, got, want);
      end
   endtask

   task automatic send_aligned(input logic [6:0] ac, a0, a1, a2, a3);
      logic [6:0] na[5];
      logic [6:0] raw[5];
      na = '{ac, a0, a1, a2, a3};
      // boundary slipped by 3 bits: raw word straddles two aligned words
      for (int l = 0; l < 5; l++) begin
         raw[l]    = {a_prev[l][2:0], na[l][6:3]};
         a_prev[l] = na[l];
      end
      wv       = 1'b1;
      clk_lane = raw[0];
      lanes    = {raw[4], raw[3], raw[2], raw[1]};
      model_word(raw);
      @(posedge clk);
      #1;
      check_status();
   endtask

   task automatic idle();
      wv       = 1'b0;
      clk_lane = 7'($urandom);
      lanes    = 28'($urandom);
      @(posedge clk);
      #1;
      check_status();
   endtask

   task automatic send_pix(input logic [23:0] c, input logic hs, vs, de,
                           input logic [6:0] ck, input bit gaps);
      logic [7:0] r, g, b;
      if (gaps) repeat ($urandom_range(0, 1)) idle();
      r = c[23:16];
      g = c[15:8];
      b = c[7:0];
      send_aligned(ck,
                   {g[0], r[5:0]},
                   {b[1:0], g[5:1]},
                   {de, vs, hs, b[5:2]},
                   {1'($urandom), b[7:6], g[7:6], r[7:6]});
   endtask

   task automatic frame(input bit gaps, input int lines, input int width, input bit mark);
      repeat (3) send_pix(24'h0, 1'b0, 1'b1, 1'b0, PAT, gaps);
      repeat (4) send_pix(24'h0, 1'b0, 1'b0, 1'b0, PAT, gaps);
      for (int ln = 0; ln < lines; ln++) begin
         for (int px = 0; px < width; px++)
            send_pix((mark && ln == 0 && px == 0) ? 24'hA53CF0 : 24'($urandom),
                     1'b0, 1'b0, 1'b1, PAT, gaps);
         for (int b = 0; b < 12; b++)
            send_pix(24'($urandom), (b < 4), 1'b0, 1'b0, PAT, gaps);
      end
   endtask

   task automatic mid_reset();
      #2 rstn = 1'b0;
      wv = 1'b0;
      #1;
      check_reset_outputs("async_reset_outputs");
      model_reset();
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rstn = 1'b1;
      check_status();
   endtask

   always @(negedge clk) begin
      if (rstn && o_valid) begin
         vectors++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL spurious_valid @%0d: got pixel color=%h de=%b, want no pixel",
                     cyc, o_color, o_de);
         end else begin
            e = sb.pop_front();
            if (o_color !== e.color || o_hs !== e.hs || o_vs !== e.vs || o_de !== e.de ||
                cyc != e.cyc || (e.de && (o_x !== 12'(e.x) || o_y !== 12'(e.y)))) begin
               errors++;
               $display("FAIL pixel @%0d: got color=%h hs/vs/de=%b%b%b x=%0d y=%0d, want @%0d color=%h hs/vs/de=%b%b%b x=%0d y=%0d",
                        cyc, o_color, o_hs, o_vs, o_de, o_x, o_y,
                        e.cyc, e.color, e.hs, e.vs, e.de, e.x, e.y);
            end
         end
      end
   end

   initial begin
      for (int l = 0; l < 5; l++) a_prev[l] = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset_outputs");
      rstn = 1'b1;

      // lock from reset with the clock lane slipped by 3 bits
      for (int i = 0; i < 7 + LOCK_COUNT + 1; i++) send_pix(24'h0, 1'b0, 1'b0, 1'b0, PAT, 1'b0);
      expect_bit("locked_within_bound", o_locked, 1'b1);
      vectors++;
      if (o_offset !== 3'd3) begin
         errors++;
         $display("FAIL offset_settle: got %0d, want 3", o_offset);
      end

      frame(1'b0, 3, 640, 1'b1);
      frame(1'b1, 3, 640, 1'b1);

      // clock-lane corruption: three tolerated, four drop lock
      repeat (5) send_pix(24'h0, 1'b0, 1'b0, 1'b0, PAT, 1'b0);
      repeat (3) send_pix(24'($urandom), 1'b0, 1'b0, 1'b1, BAD, 1'b0);
      repeat (4) send_pix(24'($urandom), 1'b0, 1'b0, 1'b1, PAT, 1'b0);
      expect_bit("lock_held_3_errs", o_locked, 1'b1);
      repeat (4) send_pix(24'($urandom), 1'b0, 1'b0, 1'b1, BAD, 1'b0);
      send_pix(24'($urandom), 1'b0, 1'b0, 1'b1, PAT, 1'b0);
      expect_bit("lock_lost_4_errs", o_locked, 1'b0);
      repeat (40) send_pix(24'($urandom), 1'b0, 1'b0, 1'b1, PAT, 1'b0);
      repeat (10) send_pix(24'h0, 1'b0, 1'b0, 1'b0, PAT, 1'b0);
      frame(1'b1, 2, 100, 1'b0);

      // asynchronous reset in the middle of a line
      repeat (50) send_pix(24'($urandom), 1'b0, 1'b0, 1'b1, PAT, 1'b0);
      mid_reset();
      repeat (24) send_pix(24'h0, 1'b0, 1'b0, 1'b0, PAT, 1'b0);
      repeat (30) send_pix(24'($urandom), 1'b0, 1'b0, 1'b1, PAT, 1'b1);
      repeat (8) send_pix(24'h0, 1'b0, 1'b0, 1'b0, PAT, 1'b1);
      frame(1'b1, 2, 64, 1'b0);

      // one over-long line drives x into saturation
      frame(1'b0, 1, 4100, 1'b0);

      repeat (4) idle();
      vectors++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d pixels never emitted, want 0", sb.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
